// File: rtl/cell_pos_pingpong.sv
// rtl/cell_pos_pingpong.sv - double-buffered per-cell particle position store
module cell_pos_pingpong #(
    parameter int DATA_WIDTH = 96,
    parameter int CELL_DEPTH = 220,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  shadow_full,
    output logic                  overflow
);

    localparam int IDX_W = (CELL_DEPTH > 1) ? $clog2(CELL_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(CELL_DEPTH - 1);

    // What the first read stage decided the answer will be.
    typedef enum logic [1:0] {
        K_ZERO  = 2'd0,
        K_COUNT = 2'd1,
        K_RAM   = 2'd2
    } rd_kind_e;

    // Counts are held per role (active/shadow) rather than per bank, so a
    // swap just moves the shadow count into the active slot.
    logic                  active_sel_q, active_sel_d;
    logic [ADDR_WIDTH-1:0] active_count_q, active_count_d;
    logic [ADDR_WIDTH-1:0] shadow_count_q, shadow_count_d;
    logic                  shadow_full_q, shadow_full_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] mem0 [CELL_DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [CELL_DEPTH];
    logic [DATA_WIDTH-1:0] ram0_q, ram1_q;

    logic                  s1_valid_q;
    logic                  s1_bank_q;
    rd_kind_e              s1_kind_q;
    logic [ADDR_WIDTH-1:0] s1_count_q;
    rd_kind_e              rd_kind;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_result;

    logic                  wr_accept;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    assign wr_accept = wr_en && !shadow_full_q && !rst;
    assign wr_idx    = IDX_W'(shadow_count_q + ADDR_WIDTH'(1));
    assign rd_idx    = IDX_W'(rd_addr);

    // Next-state for bank selection, counts and flags; an append in the swap
    // cycle lands in the outgoing shadow bank and is carried into the new active count.
    always_comb begin
        active_sel_d   = active_sel_q;
        active_count_d = active_count_q;
        shadow_count_d = shadow_count_q;
        overflow_d     = overflow_q;
        if (wr_en) begin
            if (!shadow_full_q) begin
                shadow_count_d = shadow_count_q + ADDR_WIDTH'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (swap) begin
            active_sel_d   = ~active_sel_q;
            active_count_d = shadow_count_d;
            shadow_count_d = '0;
        end
        shadow_full_d = (shadow_count_d == FULL_CNT);
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            active_sel_q   <= 1'b0;
            active_count_q <= '0;
            shadow_count_q <= '0;
            shadow_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            active_sel_q   <= active_sel_d;
            active_count_q <= active_count_d;
            shadow_count_q <= shadow_count_d;
            shadow_full_q  <= shadow_full_d;
            overflow_q     <= overflow_d;
        end
    end

    // Bank 0 RAM: written only while it is the shadow bank, registered read.
    always_ff @(posedge clock) begin
        if (wr_accept && active_sel_q) begin
            mem0[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            ram0_q <= mem0[rd_idx];
        end
    end

    // Bank 1 RAM: written only while it is the shadow bank, registered read.
    always_ff @(posedge clock) begin
        if (wr_accept && !active_sel_q) begin
            mem1[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            ram1_q <= mem1[rd_idx];
        end
    end

    // Classify the request against the active count at issue; any address
    // past the count (which also covers addresses beyond the bank) reads zero.
    always_comb begin
        rd_kind = K_ZERO;
        if (rd_addr == '0) begin
            rd_kind = K_COUNT;
        end else if (rd_addr <= active_count_q) begin
            rd_kind = K_RAM;
        end
    end

    // First read stage: capture bank, count and classification alongside the RAM access.
    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_kind_q  <= K_ZERO;
            s1_count_q <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_bank_q  <= active_sel_q;
                s1_kind_q  <= rd_kind;
                s1_count_q <= active_count_q;
            end
        end
    end

    // Select the final read word from the captured classification.
    always_comb begin
        rd_result = '0;
        case (s1_kind_q)
            K_COUNT: rd_result = DATA_WIDTH'(s1_count_q);
            K_RAM:   rd_result = s1_bank_q ? ram1_q : ram0_q;
            default: rd_result = '0;
        endcase
    end

    // Second read stage: output register, holds its value when no read completes.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rd_data_q <= rd_result;
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign active_count = active_count_q;
    assign shadow_count = shadow_count_q;
    assign shadow_full  = shadow_full_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_cell_pos_pingpong.sv
// tb/tb_cell_pos_pingpong.sv - scoreboard bench for cell_pos_pingpong
module tb_cell_pos_pingpong;

    localparam int DW    = 96;
    localparam int DEPTH = 220;
    localparam int AW    = 8;

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          swap = 1'b0;
    logic [AW-1:0] active_count, shadow_count;
    logic          shadow_full, overflow;

    logic          s_rd_en = 1'b0;
    logic [AW-1:0] s_rd_addr = '0;
    logic [DW-1:0] s_rd_data;
    logic          s_rd_valid;
    logic          s_wr_en = 1'b0;
    logic [DW-1:0] s_wr_data = '0;
    logic          s_swap = 1'b0;
    logic [AW-1:0] s_active_count, s_shadow_count;
    logic          s_shadow_full, s_overflow;

    cell_pos_pingpong #(.DATA_WIDTH(DW), .CELL_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_data(wr_data),
        .swap(swap), .active_count(active_count), .shadow_count(shadow_count),
        .shadow_full(shadow_full), .overflow(overflow)
    );

    cell_pos_pingpong #(.DATA_WIDTH(DW), .CELL_DEPTH(4), .ADDR_WIDTH(AW)) dut_small (
        .clock(clock), .rst(rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .swap(s_swap), .active_count(s_active_count), .shadow_count(s_shadow_count),
        .shadow_full(s_shadow_full), .overflow(s_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] hold_data = '0;

    logic [DW-1:0] mdl_mem [2][DEPTH];
    int            mdl_cnt [2];
    int            mdl_sel = 0;
    bit            mdl_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input int addr);
        int c;
        c = mdl_cnt[mdl_sel];
        if (addr == 0) return DW'(c);
        if (addr <= c) return mdl_mem[mdl_sel][addr];
        return '0;
    endfunction

    // Cycle counter; a sampled reset discards everything outstanding.
    always @(posedge clock) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            hold_data = '0;
            mon_en = 1'b1;
        end
    end

    // Read-side monitor: valid exactly when a read is due, data held otherwise.
    always @(negedge clock) begin
        if (mon_en) begin
            logic due_now;
            due_now = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            check_eq("rd_valid", rd_valid, due_now);
            if (due_now) begin
                check_eq("rd_data", rd_data, sb_q[0].data);
                hold_data = sb_q[0].data;
                void'(sb_q.pop_front());
            end else begin
                check_eq("rd_data_hold", rd_data, hold_data);
            end
        end
    end

    // One cycle of main-DUT stimulus; checks registered state first, then
    // pushes expected read data and advances the reference model.
    task automatic drive(input logic r, input logic re, input int ra,
                         input logic we, input logic [DW-1:0] wd, input logic sw);
        int sh;
        @(posedge clock);
        #2;
        if (mon_en) begin
            sh = 1 - mdl_sel;
            check_eq("active_count", active_count, mdl_cnt[mdl_sel]);
            check_eq("shadow_count", shadow_count, mdl_cnt[sh]);
            check_eq("shadow_full", shadow_full, mdl_cnt[sh] == DEPTH - 1);
            check_eq("overflow", overflow, mdl_ovf);
        end
        rst = r; rd_en = re; rd_addr = AW'(ra); wr_en = we; wr_data = wd; swap = sw;
        if (r) begin
            mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_sel = 0; mdl_ovf = 1'b0;
        end else begin
            if (re) sb_q.push_back('{due: cyc + 2, data: exp_read(ra)});
            sh = 1 - mdl_sel;
            if (we) begin
                if (mdl_cnt[sh] < DEPTH - 1) begin
                    mdl_cnt[sh]++;
                    mdl_mem[sh][mdl_cnt[sh]] = wd;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
            if (sw) begin
                mdl_cnt[mdl_sel] = 0;
                mdl_sel = sh;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] wa, wb, wc, wd;
        logic [DW-1:0] sw_words [4];
        wa = {32'haaaa_0001, 32'haaaa_0002, 32'haaaa_0003};
        wb = {32'hbbbb_0001, 32'hbbbb_0002, 32'hbbbb_0003};
        wc = {32'hcccc_0001, 32'hcccc_0002, 32'hcccc_0003};
        wd = {32'hdddd_0001, 32'hdddd_0002, 32'hdddd_0003};
        mdl_cnt[0] = 0; mdl_cnt[1] = 0;

        // Reset, then count read of an empty cell.
        drive(1, 0, 0, 0, '0, 0);
        drive(1, 0, 0, 0, '0, 0);
        drive(0, 1, 0, 0, '0, 0);
        idle(3);

        // Append A,B,C, swap, read back 0..4 back-to-back.
        drive(0, 0, 0, 1, wa, 0);
        drive(0, 0, 0, 1, wb, 0);
        drive(0, 0, 0, 1, wc, 0);
        drive(0, 0, 0, 0, '0, 1);
        for (int a = 0; a < 5; a++) drive(0, 1, a, 0, '0, 0);
        idle(3);

        // Swap with simultaneous append of D and a read of the old bank.
        drive(0, 0, 0, 1, wa, 0);
        drive(0, 1, 2, 1, wd, 1);
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 1, 2, 0, '0, 0);
        drive(0, 1, 1, 0, '0, 0);
        idle(3);

        // Continuous reads of the active bank while the shadow bank fills.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, i % 4, 1, {$urandom, $urandom, $urandom}, 0);
        end
        idle(3);

        // Small-depth instance: saturation, sticky overflow, out-of-range read.
        for (int i = 0; i < 4; i++) sw_words[i] = {3{32'h5000_0000 + 32'(i)}};
        for (int i = 0; i <= 4; i++) begin
            @(posedge clock);
            #2;
            check_eq("small_shadow_count", s_shadow_count, (i > 3) ? 3 : i);
            check_eq("small_shadow_full", s_shadow_full, i >= 3);
            check_eq("small_overflow", s_overflow, i >= 4);
            s_wr_en = (i < 4);
            s_wr_data = (i < 4) ? sw_words[i] : '0;
            s_swap = (i == 4);
        end
        @(posedge clock);
        #2;
        s_swap = 1'b0;
        check_eq("small_active_after_swap", s_active_count, 3);
        check_eq("small_shadow_after_swap", s_shadow_count, 0);
        check_eq("small_full_after_swap", s_shadow_full, 0);
        check_eq("small_overflow_sticky", s_overflow, 1);
        s_rd_en = 1'b1; s_rd_addr = 3;
        @(posedge clock);
        #2;
        s_rd_addr = 4;
        @(posedge clock);
        #2;
        s_rd_en = 1'b0;
        check_eq("small_rd_valid_slot3", s_rd_valid, 1);
        check_eq("small_rd_slot3", s_rd_data, sw_words[2]);
        @(posedge clock);
        #2;
        check_eq("small_rd_valid_addr4", s_rd_valid, 1);
        check_eq("small_rd_addr4_zero", s_rd_data, 0);

        // Reset with shadow_count=5 and reads in flight.
        drive(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, {3{32'h7000_0000 + 32'(i)}}, 0);
        drive(0, 1, 1, 0, '0, 0);
        drive(1, 1, 2, 1, wa, 1);
        drive(0, 0, 0, 0, '0, 0);
        check_eq("active_sel_after_rst", dut.active_sel_q, 0);
        drive(0, 1, 0, 0, '0, 0);
        idle(4);

        check_eq("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cell_pos_pingpong.md
# cell_pos_pingpong

Parametrised, double-buffered successor to the per-cell position memories. It holds the particle positions of one cell, packed as {posz, posy, posx}, in two banks. The force-evaluation side reads the active bank with fixed 2-cycle latency, while the motion-update side appends migrated or updated particles into the shadow bank. A single swap pulse exchanges the banks at the end of a timestep. Particle counts live in registers, and address 0 of the read port returns the active count, the same data organisation as the existing cell memories.

## Interface
Parameters:
- DATA_WIDTH, 96: width of one position word {posz, posy, posx}.
- CELL_DEPTH, 220: words per bank, including slot 0 (the count slot), so capacity is CELL_DEPTH-1 particles.
- ADDR_WIDTH, 8: read address width; must satisfy 2^ADDR_WIDTH >= CELL_DEPTH.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  0 = count; 1..count = particle slot.
- rd_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  qualifies rd_data.
- wr_en  in  1  append one particle to the shadow bank.
- wr_data  in  DATA_WIDTH  particle position to append.
- swap  in  1  one-cycle pulse; exchanges active and shadow banks.
- active_count  out  ADDR_WIDTH  particles in the active bank (registered).
- shadow_count  out  ADDR_WIDTH  particles in the shadow bank (registered).
- shadow_full  out  1  registered; high when shadow_count == CELL_DEPTH-1.
- overflow  out  1  sticky; set when an append is dropped.

## Operation
- State: active_sel (1 bit), count0, count1, overflow flag, and two RAM banks of CELL_DEPTH x DATA_WIDTH (inferred block RAM, single registered read).
- Reset: active_sel=0, both counts=0, overflow=0, in-flight reads discarded. rd_valid=0 and rd_data=0 from the first cycle after rst is sampled. RAM contents are not cleared.
- Append when wr_en=1 and not full: write wr_data to the shadow bank at slot shadow_count+1, then shadow_count increments by 1.
- Append when full (shadow_count == CELL_DEPTH-1): no write, count unchanged, overflow set to 1. Overflow clears only on rst.
- Swap: active_sel toggles. The old active bank becomes the shadow bank and its count resets to 0. The new active bank keeps its count.
- Append and swap in the same cycle: the append is applied to the pre-swap shadow bank and is counted, and that bank then becomes active. The new shadow count is 0.
- Read when rd_en=1: bank and count are captured at issue, from pre-swap state if swap is in the same cycle.
  - rd_addr=0 returns the count zero-extended to DATA_WIDTH.
  - 1 <= rd_addr <= count returns the RAM word.
  - rd_addr > count, or rd_addr >= CELL_DEPTH, returns all zeros (force-to-zero).
- Read while swap is in flight: a read issued before or with a swap completes from its captured bank. Appends can never target a bank that has reads in flight, because appends go only to the shadow bank.
- Idle reads: when rd_en=0, rd_valid=0 two cycles later and rd_data holds its previous value.
- Reset mid-operation: a pending append or swap in the rst cycle is ignored, and state is forced to its reset values.

## Timing
- Read latency is exactly 2 cycles: request at edge T gives rd_data/rd_valid at edge T+2. Fully pipelined, one read per cycle, no backpressure.
- Append is accepted in 1 cycle with no handshake. shadow_count and shadow_full update at the edge following wr_en.
- Swap takes effect at the next edge. A read issued in the cycle after swap sees the new active bank and active_count.
- Reads and appends may occur in the same cycle every cycle, because they target different banks. A read and a write never collide on one bank.
- Counts are 0..CELL_DEPTH-1 and cannot wrap: saturation is enforced by the full check.

## Test plan
- Reset, then read addr 0 → rd_data=0, rd_valid=1 at T+2, active_count=0, shadow_count=0, overflow=0.
- Append 3 words A,B,C, then swap, then read addr 0,1,2,3,4 back-to-back → 3, A, B, C, 0 on consecutive cycles, each 2 cycles after its request. shadow_count=0 after the swap.
- Swap with a simultaneous append of D (shadow already holding A), plus a read issued in the same cycle → read returns old-bank data. After the swap, active_count=2 and addr 2 returns D.
- CELL_DEPTH=4: append 4 words → first 3 stored, shadow_full=1 after the 3rd, 4th dropped, overflow=1 and stays high across a later swap.
- Continuous reads of the active bank while appending to the shadow bank for 20 cycles → active data unchanged, no stalls, rd_valid high every cycle.
- Assert rst with 2 reads in flight and shadow_count=5 → rd_valid=0 next cycle, both counts 0, active_sel back to bank 0.
